// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states and line-level constants.
// These constants are also used by rcv_block so both ends agree on framing.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_START_BIT  = 1'b0;
  localparam logic UART_STOP_BIT   = 1'b1;
  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_timer.sv
// Bit-period counter plus data-bit index for the UART transmitter.
// bit_done marks the final clock of the current serial bit.
module uart_tx_timer
  import uart_pkg::*;
#(
  parameter int BIT_PERIOD = 10
) (
  input  logic clk,
  input  logic n_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_bit_done,
  output logic o_last_data_bit
);

  localparam int CW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;

  logic [CW-1:0] r_count;
  logic [2:0]    r_index;
  logic          w_rollover;

  assign w_rollover      = (r_count == CW'(BIT_PERIOD - 1));
  assign o_bit_done      = i_enable && w_rollover;
  assign o_last_data_bit = (r_index == 3'(UART_DATA_BITS - 1));

  // Clear wins over counting so a new bit phase always starts from zero.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
      r_index <= '0;
    end else if (i_clear) begin
      r_count <= '0;
      r_index <= '0;
    end else if (i_enable) begin
      if (w_rollover) begin
        r_count <= '0;
        r_index <= r_index + 3'd1;
      end else begin
        r_count <= r_count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/uart_tx_block.sv
// UART transmitter: 1 start bit, 8 data bits LSB-first, 1 stop bit, all outputs registered.
// Define UART_TX_HOLD_EN to add a one-entry holding register for back-to-back frames.
module uart_tx_block
  import uart_pkg::*;
#(
  parameter int BIT_PERIOD = 10
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] tx_data,
  input  logic       load_data,
  output logic       serial_out,
  output logic       tx_busy,
  output logic       tx_ready
);

  tx_state_t  r_state, w_state_d;
  logic [7:0] r_shift, w_shift_d;
  logic       r_serial, r_busy, r_ready;
  logic       w_serial_d, w_busy_d, w_ready_d;
  logic       w_accept, w_bit_done, w_last_bit, w_timer_clear, w_timer_en;
`ifdef UART_TX_HOLD_EN
  logic [7:0] r_hold_data, w_hold_data_d;
  logic       r_hold_valid, w_hold_valid_d;
`endif

  assign w_accept      = load_data && r_ready;
  assign w_timer_en    = (r_state != IDLE);
  assign w_timer_clear = ((w_state_d == START) && (r_state != START)) ||
                         ((w_state_d == DATA) && (r_state == START));

  uart_tx_timer #(.BIT_PERIOD(BIT_PERIOD)) u_timer (
    .clk             (clk),
    .n_rst           (n_rst),
    .i_clear         (w_timer_clear),
    .i_enable        (w_timer_en),
    .o_bit_done      (w_bit_done),
    .o_last_data_bit (w_last_bit)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_serial <= UART_IDLE_LEVEL;
      r_busy   <= 1'b0;
      r_ready  <= 1'b1;
`ifdef UART_TX_HOLD_EN
      r_hold_data  <= '0;
      r_hold_valid <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_d;
      r_shift  <= w_shift_d;
      r_serial <= w_serial_d;
      r_busy   <= w_busy_d;
      r_ready  <= w_ready_d;
`ifdef UART_TX_HOLD_EN
      r_hold_data  <= w_hold_data_d;
      r_hold_valid <= w_hold_valid_d;
`endif
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_shift_d = r_shift;
`ifdef UART_TX_HOLD_EN
    w_hold_data_d  = r_hold_data;
    w_hold_valid_d = r_hold_valid;
`endif
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_d = START;
          w_shift_d = tx_data;
        end
      end
      START: begin
        if (w_bit_done) w_state_d = DATA;
      end
      DATA: begin
        if (w_bit_done) begin
          w_shift_d = r_shift >> 1;
          if (w_last_bit) w_state_d = STOP;
        end
      end
      STOP: begin
        if (w_bit_done) begin
`ifdef UART_TX_HOLD_EN
          if (r_hold_valid) begin
            w_state_d      = START;
            w_shift_d      = r_hold_data;
            w_hold_valid_d = 1'b0;
          end else if (w_accept) begin
            w_state_d = START;
            w_shift_d = tx_data;
          end else begin
            w_state_d = IDLE;
          end
`else
          w_state_d = IDLE;
`endif
        end
      end
      default: w_state_d = IDLE;
    endcase
`ifdef UART_TX_HOLD_EN
    // A load on the final stop clock goes straight to the shifter, not the holding register.
    if (w_accept && ((r_state == START) || (r_state == DATA) ||
                     ((r_state == STOP) && !w_bit_done))) begin
      w_hold_data_d  = tx_data;
      w_hold_valid_d = 1'b1;
    end
`endif
  end

  // Outputs are computed from the next state so they register in step with it.
  always_comb begin
    w_busy_d = (w_state_d != IDLE);
    case (w_state_d)
      START:   w_serial_d = UART_START_BIT;
      DATA:    w_serial_d = w_shift_d[0];
      STOP:    w_serial_d = UART_STOP_BIT;
      default: w_serial_d = UART_IDLE_LEVEL;
    endcase
`ifdef UART_TX_HOLD_EN
    w_ready_d = !w_hold_valid_d;
`else
    w_ready_d = (w_state_d == IDLE);
`endif
  end

  assign serial_out = r_serial;
  assign tx_busy    = r_busy;
  assign tx_ready   = r_ready;

endmodule
